// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   - default WIDTH / STEP / RAS_DEPTH values
//   - pc_sel_e: next-PC source select
//   - align_mask(): mask that clears the low log2(step) address bits
package pc_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_STEP      = 4;
  localparam int DEF_RAS_DEPTH = 4;
  localparam int MASK_W        = 64;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_TRAP,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

  // STEP is a power of two, so ~(STEP-1) keeps everything above the step bits.
  function automatic logic [MASK_W-1:0] align_mask(input int step);
    logic [MASK_W-1:0] s;
    s = MASK_W'(step);
    return ~(s - 1'b1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's control, target and status signals.
//   master : drives startPC, stall, trap, trap_vector, ret, call, jump,
//            jump_target, branch_taken, branch_offset; observes PC, PC_plus_step
//            and the RAS status flags.
//   slave  : the sequencer side (directions reversed).
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] startPC;
  logic             stall;
  logic             trap;
  logic [WIDTH-1:0] trap_vector;
  logic             ret;
  logic             call;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_offset;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_plus_step;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output startPC, stall, trap, trap_vector, ret, call, jump, jump_target,
           branch_taken, branch_offset,
    input  PC, PC_plus_step, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  startPC, stall, trap, trap_vector, ret, call, jump, jump_target,
           branch_taken, branch_offset,
    output PC, PC_plus_step, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   CLK, MasterReset_L : falling-edge clock, synchronous active-low reset
//   i_push/i_push_data : push a return address (overwrites oldest when full)
//   i_pop              : drop the top entry (no effect when empty)
//   o_top              : current top entry (pre-edge contents)
//   o_count            : number of valid entries, 0..RAS_DEPTH
//   o_empty/o_full     : decoded from o_count
//   o_overflow/o_underflow : single-cycle pulses for push-when-full / pop-when-empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             MasterReset_L,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;    // next slot to write; top lives at r_ptr-1
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_top_idx;

  assign w_top_idx   = r_ptr - 1'b1;
  assign o_top       = r_mem[w_top_idx];
  assign o_count     = r_count;
  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(RAS_DEPTH));
  assign o_overflow  = i_push & o_full;
  assign o_underflow = i_pop & o_empty;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(negedge CLK) begin
    if (MasterReset_L && i_push)
      r_mem[r_ptr] <= i_push_data;
  end

  always_ff @(negedge CLK) begin
    if (!MasterReset_L) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      // When full the pointer still advances, so the oldest entry is reused.
      r_ptr <= r_ptr + 1'b1;
      if (!o_full)
        r_count <= r_count + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter with stall, trap, call/return, jump and
// PC-relative branch. State updates on the falling edge of CLK.
//   CLK, MasterReset_L : clock and synchronous active-low reset
//   bus (slave)        : startPC, stall, trap/trap_vector, ret, call, jump,
//                        jump_target, branch_taken/branch_offset in;
//                        PC, PC_plus_step and RAS status flags out
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STEP      = DEF_STEP,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic           CLK,
  input  logic           MasterReset_L,
  pc_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN  = WIDTH'(align_mask(STEP));

  logic        [WIDTH-1:0] r_pc;
  logic                    r_ovf;
  logic                    r_unf;
  logic        [WIDTH-1:0] w_pc_plus;
  logic signed [WIDTH-1:0] w_offset;
  logic        [WIDTH-1:0] w_next_pc;
  pc_sel_e                 w_sel;
  logic                    w_push;
  logic                    w_pop;
  logic        [WIDTH-1:0] w_top;
  logic        [CNT_W-1:0] w_count;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_ovf_pulse;
  logic                    w_unf_pulse;

  assign w_pc_plus = r_pc + STEP_W;
  assign w_offset  = bus.branch_offset;

  always_comb begin
    w_sel = SEL_SEQ;
    if (bus.stall)             w_sel = SEL_HOLD;
    else if (bus.trap)         w_sel = SEL_TRAP;
    else if (bus.ret)          w_sel = SEL_RET;
    else if (bus.call)         w_sel = SEL_CALL;
    else if (bus.jump)         w_sel = SEL_JUMP;
    else if (bus.branch_taken) w_sel = SEL_BRANCH;
  end

  // Only the winning source touches the stack.
  assign w_push = (w_sel == SEL_CALL);
  assign w_pop  = (w_sel == SEL_RET);

  always_comb begin
    w_next_pc = w_pc_plus;
    unique case (w_sel)
      SEL_HOLD:   w_next_pc = r_pc;
      SEL_TRAP:   w_next_pc = bus.trap_vector & ALIGN;
      // Return on an empty stack falls through to the sequential address.
      SEL_RET:    w_next_pc = (w_count != '0) ? w_top : w_pc_plus;
      SEL_CALL:   w_next_pc = bus.jump_target & ALIGN;
      SEL_JUMP:   w_next_pc = bus.jump_target & ALIGN;
      SEL_BRANCH: w_next_pc = (w_pc_plus + WIDTH'(w_offset)) & ALIGN;
      SEL_SEQ:    w_next_pc = w_pc_plus;
      default:    w_next_pc = w_pc_plus;
    endcase
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK           (CLK),
    .MasterReset_L (MasterReset_L),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_push_data   (w_pc_plus),
    .o_top         (w_top),
    .o_count       (w_count),
    .o_empty       (w_empty),
    .o_full        (w_full),
    .o_overflow    (w_ovf_pulse),
    .o_underflow   (w_unf_pulse)
  );

  always_ff @(negedge CLK) begin
    if (!MasterReset_L) begin
      r_pc  <= bus.startPC;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_next_pc;
      r_ovf <= r_ovf | w_ovf_pulse;
      r_unf <= r_unf | w_unf_pulse;
    end
  end

  assign bus.PC            = r_pc;
  assign bus.PC_plus_step  = w_pc_plus;
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_full;
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer (WIDTH=32, STEP=4, RAS_DEPTH=4).
// Each step queues the expected PC and flags {empty,full,overflow,underflow},
// lets one falling edge pass, then pops the expectation and compares.
module tb_pc_sequencer;

  logic CLK;
  logic MasterReset_L;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH     (32),
    .STEP      (4),
    .RAS_DEPTH (4)
  ) dut (
    .CLK           (CLK),
    .MasterReset_L (MasterReset_L),
    .bus           (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic idle();
    bus.stall        = 1'b0;
    bus.trap         = 1'b0;
    bus.ret          = 1'b0;
    bus.call         = 1'b0;
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic tick(input string tag, input logic [31:0] pc, input logic [3:0] fl);
    exp_t        e;
    logic [3:0]  obs;
    logic [31:0] want_plus;
    e.tag = tag;
    e.pc  = pc;
    e.fl  = fl;
    sb.push_back(e);
    @(negedge CLK);
    #1;
    e = sb.pop_front();
    want_plus = e.pc + 32'd4;
    obs = {bus.ras_empty, bus.ras_full, bus.ras_overflow, bus.ras_underflow};
    total++;
    assert (bus.PC === e.pc) else begin
      bad++;
      $error("FAIL %s PC got=%h want=%h", e.tag, bus.PC, e.pc);
    end
    total++;
    assert (bus.PC_plus_step === want_plus) else begin
      bad++;
      $error("FAIL %s PC_plus_step got=%h want=%h", e.tag, bus.PC_plus_step, want_plus);
    end
    total++;
    assert (obs === e.fl) else begin
      bad++;
      $error("FAIL %s flags(E,F,O,U) got=%b want=%b", e.tag, obs, e.fl);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.startPC       = 32'h1000;
    bus.trap_vector   = '0;
    bus.jump_target   = '0;
    bus.branch_offset = '0;
    MasterReset_L     = 1'b0;

    // Reset then free-running sequential fetch
    tick("reset", 32'h1000, 4'b1000);
    MasterReset_L = 1'b1;
    tick("seq1", 32'h1004, 4'b1000);
    tick("seq2", 32'h1008, 4'b1000);
    tick("seq3", 32'h100C, 4'b1000);

    // Wrap at the top of the address space
    bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
    tick("jump_top", 32'hFFFF_FFFC, 4'b1000);
    idle();
    tick("wrap", 32'h0000_0000, 4'b1000);

    // Jump alignment, then negative branch
    bus.jump = 1'b1; bus.jump_target = 32'h0000_2003;
    tick("jump_align", 32'h2000, 4'b1000);
    idle();
    bus.branch_taken = 1'b1; bus.branch_offset = -32'sd8;
    tick("branch_neg", 32'h1FFC, 4'b1000);

    // Jump beats branch
    bus.jump = 1'b1; bus.jump_target = 32'h3000; bus.branch_taken = 1'b1;
    tick("jump_over_branch", 32'h3000, 4'b1000);
    idle();

    // Trap beats call and branch; no push
    bus.trap = 1'b1; bus.trap_vector = 32'h80;
    bus.call = 1'b1; bus.jump_target = 32'h500;
    bus.branch_taken = 1'b1; bus.branch_offset = 32'h40;
    tick("trap_prio", 32'h80, 4'b1000);
    bus.stall = 1'b1;
    tick("stall_prio", 32'h80, 4'b1000);
    idle();

    // Call / sequential / return
    bus.jump = 1'b1; bus.jump_target = 32'h100;
    tick("to_100", 32'h100, 4'b1000);
    idle();
    bus.call = 1'b1; bus.jump_target = 32'h400;
    tick("call_400", 32'h400, 4'b0000);
    idle();
    tick("cr_seq1", 32'h404, 4'b0000);
    tick("cr_seq2", 32'h408, 4'b0000);
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump_target = 32'h900;
    tick("ret_over_call", 32'h104, 4'b1000);
    idle();

    // Fill and overflow the RAS
    bus.jump = 1'b1; bus.jump_target = 32'h10;
    tick("to_10", 32'h10, 4'b1000);
    idle();
    bus.call = 1'b1;
    bus.jump_target = 32'h20; tick("call1", 32'h20, 4'b0000);
    bus.jump_target = 32'h30; tick("call2", 32'h30, 4'b0000);
    bus.jump_target = 32'h40; tick("call3", 32'h40, 4'b0000);
    bus.jump_target = 32'h50; tick("call4_full", 32'h50, 4'b0100);
    bus.jump_target = 32'h60; tick("call5_ovf", 32'h60, 4'b0110);
    idle();

    // Drain, oldest entry (0x14) was overwritten
    bus.ret = 1'b1;
    tick("ret1", 32'h54, 4'b0010);
    tick("ret2", 32'h44, 4'b0010);
    tick("ret3", 32'h34, 4'b0010);
    tick("ret4", 32'h24, 4'b1010);
    tick("ret5_unf", 32'h28, 4'b1011);
    idle();

    // Reset in the middle of activity
    bus.call = 1'b1;
    bus.jump_target = 32'h300; tick("mid_call1", 32'h300, 4'b0011);
    bus.jump_target = 32'h500; tick("mid_call2", 32'h500, 4'b0011);
    idle();
    bus.ret = 1'b1; MasterReset_L = 1'b0;
    tick("reset_mid", 32'h1000, 4'b1000);
    MasterReset_L = 1'b1;
    tick("ret_after_reset", 32'h1004, 4'b1001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer, successor to the fixed 32-bit +4 program counter. It holds the fetch address and advances it each cycle by a configurable step. It also supports stall, PC-relative branch, absolute jump, call/return through an internal return-address stack (RAS), and a trap vector. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- WIDTH, 32, PC and address width in bits
- STEP, 4, sequential increment in bytes; power of two, ≥1
- RAS_DEPTH, 4, return-address stack entries; power of two, ≥2

Ports:
- CLK  in  1  clock; all state updates on the falling edge (negedge CLK)
- MasterReset_L  in  1  reset, synchronous, active-low
- startPC  in  WIDTH  address loaded on reset
- stall  in  1  hold PC and RAS
- trap  in  1  redirect to trap_vector
- trap_vector  in  WIDTH  trap target
- ret  in  1  return: pop RAS into PC
- call  in  1  jump to jump_target and push PC+STEP
- jump  in  1  jump to jump_target, no push
- jump_target  in  WIDTH  absolute target; low log2(STEP) bits forced to 0
- branch_taken  in  1  PC-relative redirect
- branch_offset  in  WIDTH  signed byte offset, relative to PC+STEP
- PC  out  WIDTH  current fetch address (registered)
- PC_plus_step  out  WIDTH  PC+STEP, combinational, modulo 2^WIDTH
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky; a push hit a full RAS
- ras_underflow  out  1  sticky; a pop hit an empty RAS

## Operation
- Next-PC priority is evaluated at each negedge CLK, highest first:
  1. reset
  2. stall
  3. trap
  4. ret
  5. call
  6. jump
  7. branch_taken
  8. sequential
- Only the winning source acts. Losers have no side effects: no push and no pop.
- Reset (MasterReset_L=0 at the edge): PC=startPC, RAS count=0, ras_overflow=0, ras_underflow=0. Reset overrides everything, including a call/ret in progress.
- Stall: PC, RAS contents and flags are all unchanged.
- Trap: PC=trap_vector with low bits forced to 0. RAS is unchanged.
- Ret with RAS non-empty: PC=top entry, count−1.
- Ret with RAS empty: PC=PC+STEP, ras_underflow set. Count stays 0.
- Call: PC=jump_target (aligned), push PC+STEP.
  - If the RAS is full, the oldest entry is overwritten (circular), count stays RAS_DEPTH, and ras_overflow is set.
- Jump: PC=jump_target (aligned).
- Branch: PC=PC+STEP+branch_offset, with the result's low log2(STEP) bits forced to 0.
- Sequential: PC=PC+STEP.
- Arithmetic: all adds are WIDTH bits and wrap modulo 2^WIDTH. No overflow is detected. branch_offset is two's complement.
- Sticky flags clear only on reset.
- ras_empty and ras_full are decoded from the registered count. They are valid from the first edge after reset.

## Timing
- PC updates once per negedge CLK. The redirect latency is 1 edge: inputs sampled at edge N set PC after edge N.
- PC_plus_step follows PC combinationally, with zero latency.
- All inputs must be stable across the falling edge.
- The RAS pop uses pre-edge contents. Call and ret cannot both win in the same edge (ret has priority).
- Reset values: PC=startPC, ras_empty=1, ras_full=0, ras_overflow=0, ras_underflow=0. Before the first reset edge, all outputs are X.

## Structure
- Package pc_pkg:
  - next-PC select enum: SEL_HOLD, SEL_TRAP, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_SEQ
  - alignment-mask function
  - default WIDTH/STEP/RAS_DEPTH constants
- Sub-module pc_ras:
  - circular stack with parameters WIDTH and RAS_DEPTH
  - inputs: push, pop, push_data
  - outputs: top, count, empty, full, overflow/underflow pulses
  - top-level pc_sequencer owns the priority select, the adders and the sticky flags

## Test plan
- Reset/sequential: startPC=0x1000, reset low one edge, then 3 free edges → PC=0x1000, 0x1004, 0x1008, 0x100C. ras_empty=1.
- Wrap: WIDTH=32, PC=0xFFFFFFFC, sequential edge → PC=0x00000000. Branch offset=−8 at PC=0x2000 → 0x1FFC.
- Priority: trap, call and branch asserted together, trap_vector=0x80 → PC=0x80 and the RAS count is unchanged. Same stimulus with stall=1 → PC held.
- Call/ret: at PC=0x100, call with target 0x400, then two sequential edges, then ret → PC=0x400, 0x404, 0x408, 0x104. ras_empty=1 at the end.
- RAS boundaries, RAS_DEPTH=4:
  - 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full=1, ras_overflow=1.
  - 5 rets then yield 0x54, 0x44, 0x34, 0x24, then PC+4 with ras_underflow=1.
- Reset mid-operation: RAS holding 2 entries, flags set, reset with ret=1 → PC=startPC, count=0, both flags cleared.
